// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative FP32 divider.
package fp_pkg;

  typedef enum logic [0:0] {
    FMT_FP32 = 1'b0
  } fp_fmt_e;

  typedef enum logic [0:0] {
    OP_DIV = 1'b0
  } fp_op_e;

  localparam int unsigned FP32_BIAS = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // One quotient bit per iteration: 24 mantissa bits, guard, and one sticky bit.
  localparam int unsigned DIV_ITERS = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/fp_div_round.sv
// Combinational round-to-nearest-even and FP32 packing of the raw quotient.
module fp_div_round
  import fp_pkg::*;
(
  input  logic               i_sign,
  input  logic signed [9:0]  i_exp,
  input  logic        [25:0] i_quo,
  input  logic               i_rem_nz,
  output logic        [31:0] o_r
);

  function automatic logic rne_up(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  // Exponent overflow saturates to infinity, underflow flushes to zero.
  function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255)     return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  return {s, 31'd0};
    else                   return {s, e[7:0], f};
  endfunction

  logic               w_norm;
  logic        [22:0] w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_up;
  logic               w_carry;
  logic        [22:0] w_frac;
  logic signed [9:0]  w_exp_n;
  logic signed [9:0]  w_exp_f;

  // A quotient below 1.0 has its leading one one place lower; shift left by one.
  assign w_norm   = i_quo[25];
  assign w_mant   = w_norm ? i_quo[24:2] : i_quo[23:1];
  assign w_guard  = w_norm ? i_quo[1] : i_quo[0];
  assign w_sticky = (w_norm & i_quo[0]) | i_rem_nz;
  assign w_exp_n  = w_norm ? i_exp : i_exp - 10'sd1;

  // The hidden bit is always one, so a carry happens only when the fraction is all ones.
  assign w_up     = rne_up(w_guard, w_sticky, w_mant[0]);
  assign w_frac   = w_mant + {22'd0, w_up};
  assign w_carry  = w_up & (&w_mant);
  assign w_exp_f  = w_carry ? w_exp_n + 10'sd1 : w_exp_n;

  assign o_r = pack_sat(i_sign, w_exp_f, w_frac);

endmodule

// File: rtl/fp_div_iter.sv
// Iterative FP32 divider: restoring significand division, one bit per cycle.
module fp_div_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R
);

  div_state_e         r_state;
  div_state_e         w_state_nxt;
  logic        [4:0]  r_cnt;
  logic        [25:0] r_q;
  logic        [24:0] r_rem;
  logic        [23:0] r_div;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic        [31:0] r_res;

  logic               w_sign;
  logic               w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
  logic               w_nan, w_inf, w_zero, w_special;
  logic        [31:0] w_special_r;
  logic signed [9:0]  w_exp_in;
  logic               w_ge;
  logic        [23:0] w_diff;
  logic        [24:0] w_rem_nxt;
  logic               w_last;
  logic        [31:0] w_round_r;

  // Operand classification; exponent zero is treated as zero (subnormals flushed).
  assign w_sign   = X[31] ^ Y[31];
  assign w_x_zero = (X[30:23] == 8'h00);
  assign w_y_zero = (Y[30:23] == 8'h00);
  assign w_x_inf  = (X[30:23] == 8'hFF) && (X[22:0] == 23'd0);
  assign w_y_inf  = (Y[30:23] == 8'hFF) && (Y[22:0] == 23'd0);
  assign w_x_nan  = (X[30:23] == 8'hFF) && (X[22:0] != 23'd0);
  assign w_y_nan  = (Y[30:23] == 8'hFF) && (Y[22:0] != 23'd0);

  assign w_nan     = w_x_nan | w_y_nan | (w_x_zero & w_y_zero) | (w_x_inf & w_y_inf);
  assign w_inf     = w_x_inf | w_y_zero;
  assign w_zero    = w_x_zero | w_y_inf;
  assign w_special = w_nan | w_inf | w_zero;
  assign w_special_r = w_nan ? FP32_QNAN :
                       w_inf ? {w_sign, 8'hFF, 23'd0} :
                               {w_sign, 31'd0};

  assign w_exp_in = $signed({2'b00, X[30:23]}) - $signed({2'b00, Y[30:23]})
                  + $signed(10'(FP32_BIAS));

  // Restoring step: the remainder after a successful subtract is below the divisor,
  // so the low 24 bits of the difference are exact.
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_diff    = r_rem[23:0] - r_div;
  assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};
  assign w_last    = (r_cnt == 5'(DIV_ITERS - 1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign R         = r_res;

  fp_div_round u_round (
    .i_sign   (r_sign),
    .i_exp    (r_exp),
    .i_quo    (r_q),
    .i_rem_nz (|r_rem),
    .o_r      (w_round_r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; DONE only releases on out_ready and never accepts in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_special ? DONE : DIV;
      DIV:     if (w_last) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 5'd0;
      r_q    <= 26'd0;
      r_rem  <= 25'd0;
      r_div  <= 24'd0;
      r_sign <= 1'b0;
      r_exp  <= 10'sd0;
      r_res  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_exp  <= w_exp_in;
            r_div  <= {1'b1, Y[22:0]};
            r_rem  <= {2'b01, X[22:0]};
            r_q    <= 26'd0;
            r_cnt  <= 5'd0;
            if (w_special) r_res <= w_special_r;
          end
        end
        DIV: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 5'd1;
        end
        ROUND:   r_res <= w_round_r;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for the iterative FP32 divider.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Counts cycles after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input int elat);
    int lat;
    @(negedge clk);
    check({tag, ":rdy"}, 32'(in_ready), 32'd1);
    X = x; Y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = 32'hDEADBEEF; Y = 32'h12345678;
    wait_done(lat);
    check({tag, ":lat"}, 32'(lat), 32'(elat));
    check({tag, ":R"}, R, er);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":ov_clr"}, 32'(out_valid), 32'd0);
    check({tag, ":rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:R", R, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Normal and special operand vectors.
    do_op("6/2",    32'h40C00000, 32'h40000000, 32'h40400000, 28);
    do_op("1/3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
    do_op("-6/2",   32'hC0C00000, 32'h40000000, 32'hC0400000, 28);
    do_op("1/0",    32'h3F800000, 32'h00000000, 32'h7F800000, 1);
    do_op("0/0",    32'h00000000, 32'h00000000, 32'h7FC00000, 1);
    do_op("ninf/2", 32'hFF800000, 32'h40000000, 32'hFF800000, 1);
    do_op("2/ninf", 32'h40000000, 32'hFF800000, 32'h80000000, 1);
    do_op("nan/1",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
    do_op("ovf",    32'h7F000000, 32'h3E800000, 32'h7F800000, 28);
    do_op("unf",    32'h00800000, 32'h4B000000, 32'h00000000, 28);

    // Backpressure: hold DONE for 5 cycles while a second request is waiting.
    @(negedge clk);
    X = 32'h40C00000; Y = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("bp:lat", 32'(lat), 32'd28);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      X = 32'h3F800000; Y = 32'h00000000; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp:R", R, 32'h40400000);
      check("bp:ov", 32'(out_valid), 32'd1);
      check("bp:rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp:no_bypass_ov", 32'(out_valid), 32'd0);
    check("bp:no_bypass_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp:second_ov", 32'(out_valid), 32'd1);
    check("bp:second_R", R, 32'h7F800000);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp:second_clr", 32'(out_valid), 32'd0);

    // Reset in the middle of DIV aborts the division.
    seen = 1'b0;
    @(negedge clk);
    X = 32'h40C00000; Y = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rstdiv:in_ready", 32'(in_ready), 32'd1);
    check("rstdiv:out_valid", 32'(out_valid), 32'd0);
    check("rstdiv:R", R, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("rstdiv:never_valid", 32'(seen), 32'd0);
    do_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 28);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
